// File: rtl/eth_tx_pkg.sv
// Shared types, constants and the byte-wide CRC-32 step for the Ethernet TX framer.
package eth_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_DRAIN,
      ST_IFG
   } eth_tx_state_e;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam int          PREAMBLE_LEN  = 7;

   // Reflected CRC-32, one byte per call, LSB of the byte first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
      logic [31:0] c;
      c = crc_in ^ {24'h000000, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_crc32.sv
// Running CRC-32 register: clear has priority over enable.
module eth_crc32
   import eth_tx_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [7:0]  data_i,
   input  logic        enable_i,
   input  logic        clear_i,
   output logic [31:0] crc_o
);

   logic [31:0] crc_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         crc_q <= CRC_INIT;
      end else if (clear_i) begin
         crc_q <= CRC_INIT;
      end else if (enable_i) begin
         crc_q <= crc32_byte(crc_q, data_i);
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/eth_axis_tx_framer.sv
// AXI-Stream to GMII transmit framer: preamble/SFD, payload, zero pad, FCS and inter-frame gap.
module eth_axis_tx_framer
   import eth_tx_pkg::*;
#(
   parameter int MIN_FRAME = 60,
   parameter int IFG_BYTES = 12
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [7:0]    s_axis_tdata_i,
   input  logic          s_axis_tvalid_i,
   input  logic          s_axis_tlast_i,
   input  logic          s_axis_tuser_i,
   output logic          s_axis_tready_o,
   output logic [7:0]    gmii_txd_o,
   output logic          gmii_tx_en_o,
   output logic          gmii_tx_er_o,
   output logic          busy_o,
   output logic [15:0]   frame_cnt_o,
   output eth_tx_state_e state_o
);

   localparam logic [31:0] MIN_LEN = 32'(MIN_FRAME);
   localparam logic [31:0] IFG_LEN = 32'(IFG_BYTES);

   eth_tx_state_e state_q, state_d;
   logic [7:0]    txd_q, txd_d;
   logic          tx_en_q, tx_en_d;
   logic          tx_er_q, tx_er_d;
   logic [3:0]    step_q, step_d;
   logic [15:0]   ifg_q, ifg_d;
   logic [15:0]   byte_cnt_q, byte_cnt_d;
   logic          corrupt_q, corrupt_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;

   logic [15:0]   cnt_inc;
   logic [31:0]   crc;
   logic [31:0]   fcs_word;
   logic          crc_en;
   logic          crc_clr;
   logic [7:0]    crc_data;
   logic          beat;

   // A beat transfers on a rising edge where tvalid and tready are both high;
   // tready depends only on the state, never on tvalid.
   assign s_axis_tready_o = (state_q == ST_DATA) || (state_q == ST_DRAIN);
   assign beat            = s_axis_tvalid_i && s_axis_tready_o;
   assign busy_o          = (state_q != ST_IDLE);
   assign state_o         = state_q;
   assign gmii_txd_o      = txd_q;
   assign gmii_tx_en_o    = tx_en_q;
   assign gmii_tx_er_o    = tx_er_q;
   assign frame_cnt_o     = frame_cnt_q;

   assign cnt_inc  = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
   // A corrupted frame sends the raw register so the receiver always sees a bad FCS.
   assign fcs_word = corrupt_q ? crc : ~crc;

   eth_crc32 u_crc (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .data_i   (crc_data),
      .enable_i (crc_en),
      .clear_i  (crc_clr),
      .crc_o    (crc)
   );

   always_comb begin
      state_d     = state_q;
      txd_d       = 8'h00;
      tx_en_d     = 1'b0;
      tx_er_d     = 1'b0;
      step_d      = step_q;
      ifg_d       = ifg_q;
      byte_cnt_d  = byte_cnt_q;
      corrupt_d   = corrupt_q;
      frame_cnt_d = frame_cnt_q;
      crc_en      = 1'b0;
      crc_clr     = 1'b0;
      crc_data    = 8'h00;
      case (state_q)
         ST_IDLE: begin
            crc_clr    = 1'b1;
            byte_cnt_d = 16'h0000;
            step_d     = 4'd0;
            ifg_d      = 16'h0000;
            corrupt_d  = 1'b0;
            if (s_axis_tvalid_i) begin
               state_d = ST_PREAMBLE;
               txd_d   = PREAMBLE_BYTE;
               tx_en_d = 1'b1;
            end
         end
         ST_PREAMBLE: begin
            crc_clr = 1'b1;
            tx_en_d = 1'b1;
            // IDLE already launched the first preamble byte.
            if (step_q == 4'(PREAMBLE_LEN - 1)) begin
               txd_d   = SFD_BYTE;
               step_d  = 4'd0;
               state_d = ST_DATA;
            end else begin
               txd_d  = PREAMBLE_BYTE;
               step_d = step_q + 4'd1;
            end
         end
         ST_DATA: begin
            tx_en_d = 1'b1;
            if (beat) begin
               txd_d      = s_axis_tdata_i;
               crc_en     = 1'b1;
               crc_data   = s_axis_tdata_i;
               byte_cnt_d = cnt_inc;
               if (s_axis_tlast_i) begin
                  corrupt_d = s_axis_tuser_i;
                  step_d    = 4'd0;
                  state_d   = ({16'h0000, cnt_inc} < MIN_LEN) ? ST_PAD : ST_FCS;
               end
            end else begin
               tx_er_d = 1'b1;
               state_d = ST_DRAIN;
            end
         end
         ST_PAD: begin
            tx_en_d    = 1'b1;
            crc_en     = 1'b1;
            byte_cnt_d = cnt_inc;
            if ({16'h0000, cnt_inc} >= MIN_LEN) begin
               state_d = ST_FCS;
            end
         end
         ST_FCS: begin
            tx_en_d = 1'b1;
            tx_er_d = corrupt_q;
            txd_d   = 8'(fcs_word >> {step_q[1:0], 3'b000});
            step_d  = step_q + 4'd1;
            if (step_q[1:0] == 2'd3) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               ifg_d       = 16'h0000;
               state_d     = ST_IFG;
            end
         end
         ST_DRAIN: begin
            crc_clr = 1'b1;
            if (beat && s_axis_tlast_i) begin
               ifg_d   = 16'h0000;
               state_d = ST_IFG;
            end
         end
         ST_IFG: begin
            crc_clr = 1'b1;
            ifg_d   = ifg_q + 16'd1;
            if ({16'h0000, ifg_q} + 32'd1 >= IFG_LEN) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         txd_q       <= 8'h00;
         tx_en_q     <= 1'b0;
         tx_er_q     <= 1'b0;
         step_q      <= 4'd0;
         ifg_q       <= 16'h0000;
         byte_cnt_q  <= 16'h0000;
         corrupt_q   <= 1'b0;
         frame_cnt_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         txd_q       <= txd_d;
         tx_en_q     <= tx_en_d;
         tx_er_q     <= tx_er_d;
         step_q      <= step_d;
         ifg_q       <= ifg_d;
         byte_cnt_q  <= byte_cnt_d;
         corrupt_q   <= corrupt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

endmodule
